// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - FU result ports and CDB broadcast bundle for cdb_arbiter
//
// Purpose: groups the per-FU valid/ready result ports and the registered CDB
// broadcast into one bundle.
//   slave  modport : the arbiter (consumes FU results, drives fu_ready and cdb_*)
//   master modport : the FU / consumer side (drives FU results, observes fu_ready and cdb_*)
// Signals:
//   fu_valid[i], fu_tag[i], fu_wb_en[i], fu_value[i], fu_correct_predict[i] : FU i result
//   fu_ready[i]                                                             : slot i accepts
//   cdb_no_output, cdb_tag, cdb_tag_valid, cdb_value, cdb_correct_predict   : CDB broadcast
interface cdb_arbiter_if #(
    parameter int NUM_FU = 4,
    parameter int TAG_W  = 5,
    parameter int XLEN   = 32
);
    logic [NUM_FU-1:0]            fu_valid;
    logic [NUM_FU-1:0][TAG_W-1:0] fu_tag;
    logic [NUM_FU-1:0]            fu_wb_en;
    logic [NUM_FU-1:0][XLEN-1:0]  fu_value;
    logic [NUM_FU-1:0]            fu_correct_predict;
    logic [NUM_FU-1:0]            fu_ready;

    logic                         cdb_no_output;
    logic [TAG_W-1:0]             cdb_tag;
    logic                         cdb_tag_valid;
    logic [XLEN-1:0]              cdb_value;
    logic                         cdb_correct_predict;

    modport slave (
        input  fu_valid, fu_tag, fu_wb_en, fu_value, fu_correct_predict,
        output fu_ready,
        output cdb_no_output, cdb_tag, cdb_tag_valid, cdb_value, cdb_correct_predict
    );

    modport master (
        output fu_valid, fu_tag, fu_wb_en, fu_value, fu_correct_predict,
        input  fu_ready,
        input  cdb_no_output, cdb_tag, cdb_tag_valid, cdb_value, cdb_correct_predict
    );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin Common Data Bus arbiter with one holding slot per FU
//
// Purpose: each FU result port owns a one-entry slot; full slots are granted
// round-robin, one per cycle, into a registered CDB broadcast. A squash drops
// every pending result; reset clears everything asynchronously.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-high reset
//   squash : synchronous flush of all slots and of the next broadcast
//   bus    : cdb_arbiter_if.slave (FU result ports in, fu_ready and CDB out)
module cdb_arbiter #(
    parameter int NUM_FU = 4,
    parameter int TAG_W  = 5,
    parameter int XLEN   = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         squash,
    cdb_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    // Holding slots
    logic [NUM_FU-1:0]            full_q, full_d;
    logic [NUM_FU-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [NUM_FU-1:0]            wb_en_q, wb_en_d;
    logic [NUM_FU-1:0][XLEN-1:0]  value_q, value_d;
    logic [NUM_FU-1:0]            cp_q, cp_d;

    logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;

    // CDB output register
    logic                         out_no_output_q, out_no_output_d;
    logic [TAG_W-1:0]             out_tag_q, out_tag_d;
    logic                         out_tag_valid_q, out_tag_valid_d;
    logic [XLEN-1:0]              out_value_q, out_value_d;
    logic                         out_cp_q, out_cp_d;

    logic [NUM_FU-1:0]            grant;
    logic                         any_grant;
    logic [PTR_W-1:0]             grant_idx;
    logic [PTR_W:0]               scan_sum;
    logic [PTR_W-1:0]             scan_idx;
    logic [NUM_FU-1:0]            ready;

    // Search upward from rr_ptr, wrapping; scan_sum never exceeds 2*NUM_FU-2
    // so one conditional subtraction is enough to reduce it modulo NUM_FU.
    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (scan_sum >= (PTR_W+1)'(NUM_FU)) begin
                scan_sum = scan_sum - (PTR_W+1)'(NUM_FU);
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (!any_grant && full_q[scan_idx]) begin
                any_grant       = 1'b1;
                grant_idx       = scan_idx;
                grant[scan_idx] = 1'b1;
            end
        end
    end

    // A granted slot may accept a new result at the same edge it drains,
    // which lets a lone FU sustain one result per cycle.
    always_comb begin
        ready   = '0;
        full_d  = full_q;
        tag_d   = tag_q;
        wb_en_d = wb_en_q;
        value_d = value_q;
        cp_d    = cp_q;
        for (int i = 0; i < NUM_FU; i++) begin
            ready[i] = !squash && (!full_q[i] || grant[i]);
            if (squash) begin
                full_d[i] = 1'b0;
            end else if (bus.fu_valid[i] && ready[i]) begin
                full_d[i]  = 1'b1;
                tag_d[i]   = bus.fu_tag[i];
                wb_en_d[i] = bus.fu_wb_en[i];
                value_d[i] = bus.fu_value[i];
                cp_d[i]    = bus.fu_correct_predict[i];
            end else if (grant[i]) begin
                full_d[i] = 1'b0;
            end
        end
    end

    // Squash freezes the pointer even if a slot would have been granted.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (!squash && any_grant) begin
            if (grant_idx == PTR_W'(NUM_FU - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + PTR_W'(1);
            end
        end
    end

    // Idle broadcast keeps correct_predict at 1 so the ROB never sees a
    // phantom mispredict.
    always_comb begin
        out_no_output_d = 1'b1;
        out_tag_d       = '0;
        out_tag_valid_d = 1'b0;
        out_value_d     = '0;
        out_cp_d        = 1'b1;
        if (!squash && any_grant) begin
            out_no_output_d = 1'b0;
            out_tag_d       = tag_q[grant_idx];
            out_tag_valid_d = wb_en_q[grant_idx];
            out_value_d     = value_q[grant_idx];
            out_cp_d        = cp_q[grant_idx];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full_q          <= '0;
            tag_q           <= '0;
            wb_en_q         <= '0;
            value_q         <= '0;
            cp_q            <= '0;
            rr_ptr_q        <= '0;
            out_no_output_q <= 1'b1;
            out_tag_q       <= '0;
            out_tag_valid_q <= 1'b0;
            out_value_q     <= '0;
            out_cp_q        <= 1'b1;
        end else begin
            full_q          <= full_d;
            tag_q           <= tag_d;
            wb_en_q         <= wb_en_d;
            value_q         <= value_d;
            cp_q            <= cp_d;
            rr_ptr_q        <= rr_ptr_d;
            out_no_output_q <= out_no_output_d;
            out_tag_q       <= out_tag_d;
            out_tag_valid_q <= out_tag_valid_d;
            out_value_q     <= out_value_d;
            out_cp_q        <= out_cp_d;
        end
    end

    assign bus.fu_ready            = ready;
    assign bus.cdb_no_output       = out_no_output_q;
    assign bus.cdb_tag             = out_tag_q;
    assign bus.cdb_tag_valid       = out_tag_valid_q;
    assign bus.cdb_value           = out_value_q;
    assign bus.cdb_correct_predict = out_cp_q;
endmodule
